mul_result_writeback: RTL and testbench



---
 rtl/mul_result_writeback.sv | 102 ++++++++++
 tb/tb_mul_result_writeback.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_writeback.sv
// Result writeback buffer for the multiplier: picks the upper or lower half of each
// product and queues it with its destination tag in a small FIFO for the register file.
module mul_result_writeback #(
    parameter  int MUL_SIZE   = 32,
    parameter  int ADDER_SIZE = 2 * MUL_SIZE,
    parameter  int DEPTH      = 4,
    parameter  int TAG_W      = 5,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDER_SIZE-1:0] in_res,
    input  logic                  in_sel_high,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MUL_SIZE-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      out_count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [MUL_SIZE-1:0] data;
        logic [TAG_W-1:0]    tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshake flags come only from the count register, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_count = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_entry.tag  = in_tag;
        wr_entry.data = in_sel_high ? MUL_SIZE'(in_res[ADDER_SIZE-1:MUL_SIZE])
                                    : in_res[MUL_SIZE-1:0];
    end

    // Masking the head with out_valid makes the outputs read zero during reset and when empty.
    assign head     = mem_q[rd_ptr_q];
    assign out_data = out_valid ? head.data : '0;
    assign out_tag  = out_valid ? head.tag  : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry storage has no reset; stale words are never observed because the
    // outputs are masked by out_valid, which keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: tb/tb_mul_result_writeback.sv
// Scoreboard bench for mul_result_writeback: directed pushes queue their expected
// head values; an independent monitor pops and compares on every output handshake.
module tb_mul_result_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_res;
    logic        in_sel_high;
    logic [4:0]  in_tag;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [2:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {data, tag} in delivery order.
    logic [36:0] sb[$];

    mul_result_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .in_res      (in_res),
        .in_sel_high (in_sel_high),
        .in_tag      (in_tag),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake that will fire at the coming edge is sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'hDEAD);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e[36:5]));
                check("out_tag",  64'(out_tag),  64'(e[4:0]));
            end
        end
    end

    task automatic do_push(input logic [63:0] res, input logic sel, input logic [4:0] tag,
                           input logic [31:0] exp);
        bit accepted = 0;
        in_res      = res;
        in_sel_high = sel;
        in_tag      = tag;
        in_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({exp, tag});
                accepted = 1;
                break;
            end
        end
        if (!accepted) check("push_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_res = '0; in_sel_high = 0; in_tag = '0;
        in_valid = 0; out_ready = 0; flush = 0;
        #2;
        check("rst_count",  64'(out_count), 64'd0);
        check("rst_ready",  64'(in_ready),  64'd1);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_data",   64'(out_data),  64'd0);
        check("rst_tag",    64'(out_tag),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Low half select, one-cycle latency.
        do_push(64'h0000_0001_FFFF_FFFE, 1'b0, 5'd3, 32'hFFFF_FFFE);
        check("lo_valid", 64'(out_valid), 64'd1);
        check("lo_count", 64'(out_count), 64'd1);
        check("lo_data",  64'(out_data),  64'hFFFF_FFFE);
        check("lo_tag",   64'(out_tag),   64'd3);
        drain();

        // High half select.
        do_push(64'h0000_0001_FFFF_FFFE, 1'b1, 5'd7, 32'h0000_0001);
        check("hi_data", 64'(out_data), 64'h1);
        check("hi_tag",  64'(out_tag),  64'd7);
        drain();

        // Fill to full, fifth push held until the first pop edge.
        for (int i = 1; i <= 4; i++)
            do_push({32'h1234_5678, 32'(i)}, 1'b0, 5'(i), 32'(i));
        check("full_count", 64'(out_count), 64'd4);
        check("full_ready", 64'(in_ready),  64'd0);
        in_res = {32'h1234_5678, 32'd5}; in_sel_high = 0; in_tag = 5'd5; in_valid = 1;
        sb.push_back({32'd5, 5'd5});
        @(posedge clk); #1;
        check("held_count", 64'(out_count), 64'd4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("pop_no_push_count", 64'(out_count), 64'd3);
        check("pop_ready",         64'(in_ready),  64'd1);
        @(posedge clk); #1;
        check("push_pop_count", 64'(out_count), 64'd3);
        in_valid = 0;
        drain();

        // Steady state at count 2 with simultaneous push/pop, pointers wrapping.
        do_push({32'd10, 32'hDEAD_BEEF}, 1'b1, 5'd10, 32'd10);
        do_push({32'd11, 32'hDEAD_BEEF}, 1'b1, 5'd11, 32'd11);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel_high = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_res = {32'(12 + i), 32'hDEAD_BEEF};
            in_tag = 5'(12 + i);
            sb.push_back({32'(12 + i), 5'(12 + i)});
            @(posedge clk); #1;
            check("steady_count", 64'(out_count), 64'd2);
        end
        in_valid = 0;
        drain();

        // Flush overrides concurrent push and pop.
        for (int i = 0; i < 3; i++)
            do_push({32'h0, 32'(20 + i)}, 1'b0, 5'(20 + i), 32'(20 + i));
        check("pre_flush_count", 64'(out_count), 64'd3);
        flush = 1; in_valid = 1; in_res = {32'h0, 32'd99}; in_sel_high = 0; in_tag = 5'd9;
        out_ready = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0; out_ready = 0;
        sb.delete();
        check("flush_count", 64'(out_count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready),  64'd1);
        do_push({32'h0, 32'h42}, 1'b0, 5'd1, 32'h42);
        check("post_flush_data", 64'(out_data), 64'h42);
        drain();

        // Asynchronous reset between edges with two entries buffered.
        do_push({32'h0, 32'd30}, 1'b0, 5'd30, 32'd30);
        do_push({32'h0, 32'd31}, 1'b0, 5'd31, 32'd31);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_count", 64'(out_count), 64'd0);
        check("arst_ready", 64'(in_ready),  64'd1);
        check("arst_data",  64'(out_data),  64'd0);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++)
            do_push({32'(40 + i), 32'h0}, 1'b1, 5'(i), 32'(40 + i));
        check("post_rst_count", 64'(out_count), 64'd3);
        drain();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
